// File: rtl/intersection_controller.sv
// Two-way intersection lamp sequencer with a down-counting phase timer.
// Optional pedestrian WALK phase enabled by defining INTERSECTION_PED_EN.
module intersection_controller #(
  parameter int unsigned GREEN_CYC  = 8,
  parameter int unsigned YELLOW_CYC = 3,
  parameter int unsigned ALLRED_CYC = 1,
  parameter int unsigned WALK_CYC   = 5,
  parameter int unsigned TMR_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       ew_sensor,
  input  logic       ped_req,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_NS_G = 3'd0,
    S_NS_Y = 3'd1,
    S_AR1  = 3'd2,
    S_EW_G = 3'd3,
    S_EW_Y = 3'd4,
    S_AR2  = 3'd5,
    S_WALK = 3'd6
  } state_t;

  localparam logic [TMR_W-1:0] T_GREEN  = TMR_W'(GREEN_CYC - 1);
  localparam logic [TMR_W-1:0] T_YELLOW = TMR_W'(YELLOW_CYC - 1);
  localparam logic [TMR_W-1:0] T_ALLRED = TMR_W'(ALLRED_CYC - 1);
  localparam logic [TMR_W-1:0] T_WALK   = TMR_W'(WALK_CYC - 1);

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             expired;

  function automatic logic [TMR_W-1:0] load_of(input state_t s);
    case (s)
      S_NS_G, S_EW_G: load_of = T_GREEN;
      S_NS_Y, S_EW_Y: load_of = T_YELLOW;
      S_WALK:         load_of = T_WALK;
      default:        load_of = T_ALLRED;
    endcase
  endfunction

`ifdef INTERSECTION_PED_EN
  logic pend, pend_nxt;
  // the request seen on the clearing edge itself stays latched for next round
  assign pend_nxt = ped_req | (pend & ~(state == S_AR2 && state_nxt == S_WALK));
`else
  logic unused_ped;
  assign unused_ped = ped_req;
`endif

  assign expired = (timer == '0);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      S_NS_G: if (enable && expired && ew_sensor) state_nxt = S_NS_Y;
      S_NS_Y: if (enable && expired) state_nxt = S_AR1;
      S_AR1:  if (enable && expired) state_nxt = S_EW_G;
      S_EW_G: if (enable && expired) state_nxt = S_EW_Y;
      S_EW_Y: if (enable && expired) state_nxt = S_AR2;
      S_AR2: begin
        if (enable && expired) begin
`ifdef INTERSECTION_PED_EN
          state_nxt = pend ? S_WALK : S_NS_G;
`else
          state_nxt = S_NS_G;
`endif
        end
      end
`ifdef INTERSECTION_PED_EN
      S_WALK: if (enable && expired) state_nxt = S_NS_G;
`endif
      default: state_nxt = S_AR2;
    endcase
    // any state change (including illegal-code recovery) reloads the timer
    if (state_nxt != state) timer_nxt = load_of(state_nxt);
    else if (enable && !expired) timer_nxt = timer - TMR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_AR2;
      timer <= T_ALLRED;
`ifdef INTERSECTION_PED_EN
      pend  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
`ifdef INTERSECTION_PED_EN
      pend  <= pend_nxt;
`endif
    end
  end

  always_comb begin
    ns_red    = 1'b1;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b1;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    case (state)
      S_NS_G: begin ns_red = 1'b0; ns_green  = 1'b1; end
      S_NS_Y: begin ns_red = 1'b0; ns_yellow = 1'b1; end
      S_EW_G: begin ew_red = 1'b0; ew_green  = 1'b1; end
      S_EW_Y: begin ew_red = 1'b0; ew_yellow = 1'b1; end
      default: ;
    endcase
  end

`ifdef INTERSECTION_PED_EN
  assign walk    = (state == S_WALK);
  assign ped_ack = (state == S_WALK) && (timer == T_WALK);
`else
  assign walk    = 1'b0;
  assign ped_ack = 1'b0;
`endif

  assign phase = state;

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench for intersection_controller: stimulus table, directed corner
// sequences and randomized traffic against an elapsed-cycle reference model.
module tb_intersection_controller;

  localparam int GREEN  = 8;
  localparam int YELLOW = 3;
  localparam int ALLRED = 1;
  localparam int WALKC  = 5;
`ifdef INTERSECTION_PED_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, enable, ew_sensor, ped_req;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_ack;
  logic [2:0] phase;

  intersection_controller #(
    .GREEN_CYC(GREEN), .YELLOW_CYC(YELLOW), .ALLRED_CYC(ALLRED),
    .WALK_CYC(WALKC), .TMR_W(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ew_sensor(ew_sensor), .ped_req(ped_req),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk(walk), .ped_ack(ped_ack), .phase(phase)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: current phase, cycles already spent in it, pending request
  int m_ph, m_cnt;
  bit m_pend;

  function automatic int dur(input int ph);
    case (ph)
      0, 3:    dur = GREEN;
      1, 4:    dur = YELLOW;
      6:       dur = WALKC;
      default: dur = ALLRED;
    endcase
  endfunction

  // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
  function automatic logic [6:0] exp_lamps(input int ph);
    case (ph)
      0:       exp_lamps = 7'b0011000;
      1:       exp_lamps = 7'b0101000;
      3:       exp_lamps = 7'b1000010;
      4:       exp_lamps = 7'b1000100;
      6:       exp_lamps = 7'b1001001;
      default: exp_lamps = 7'b1001000;
    endcase
  endfunction

  function automatic logic [6:0] lamps();
    lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};
  endfunction

  task automatic model_reset();
    m_ph = 5; m_cnt = 0; m_pend = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit sens, input bit ped);
    bit cleared = 1'b0;
    if (en) begin
      if (m_cnt + 1 < dur(m_ph)) m_cnt++;
      else if (m_ph == 0 && !sens) ;
      else begin
        case (m_ph)
          5: begin
            if (PED && m_pend) begin m_ph = 6; cleared = 1'b1; end
            else m_ph = 0;
          end
          6:       m_ph = 0;
          default: m_ph = m_ph + 1;
        endcase
        m_cnt = 0;
      end
    end
    m_pend = PED && (ped || (m_pend && !cleared));
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_phase"}, 32'(phase), 32'(m_ph));
    check({tag, "_lamps"}, 32'(lamps()), 32'(exp_lamps(m_ph)));
    check({tag, "_ack"}, 32'(ped_ack), 32'(PED && m_ph == 6 && m_cnt == 0));
  endtask

  task automatic step(input bit en, input bit sens, input bit ped, input string tag);
    enable = en; ew_sensor = sens; ped_req = ped;
    @(posedge clk);
    model_step(en, sens, ped);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_model({tag, "_async"});
    check({tag, "_rst_phase"}, 32'(phase), 32'd5);
    @(posedge clk);
    #1;
    check_model({tag, "_held"});
    reset = 1'b0;
  endtask

  task automatic run_until(input int ph, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step(1'b1, 1'b1, 1'b0, tag);
      hit = (phase == 3'(ph));
    end
    check({tag, "_reached"}, 32'(hit), 32'd1);
  endtask

  typedef struct { bit en; bit sens; bit ped; int ph; } vec_t;
  vec_t tbl[$];

  task automatic add_run(input int ph, input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.en = 1'b1; v.sens = 1'b1; v.ped = !PED; v.ph = ph;
      tbl.push_back(v);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, ack_cnt, walk_cnt;
    bit saw_walk;
    reset = 1'b1; enable = 1'b0; ew_sensor = 1'b0; ped_req = 1'b0;
    model_reset();

    // two full 24-cycle periods of the default cadence
    for (int r = 0; r < 2; r++) begin
      add_run(0, 8); add_run(1, 3); add_run(2, 1);
      add_run(3, 8); add_run(4, 3); add_run(5, 1);
    end
    add_run(0, 1);

    do_reset("init");
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].sens, tbl[i].ped, "tbl");
      check("tbl_phase", 32'(phase), 32'(tbl[i].ph));
      check("tbl_lamps", 32'(lamps()), 32'(exp_lamps(tbl[i].ph)));
    end

    // NS green held by absent EW traffic, released at cycle 20
    do_reset("hold");
    n = 0;
    for (int i = 0; i < 21; i++) begin
      step(1'b1, 1'b0, 1'b0, "hold");
      if (phase == 3'd0) n++;
    end
    step(1'b1, 1'b1, 1'b0, "hold");
    check("hold_nsg_len", 32'(n), 32'd21);
    check("hold_exit", 32'(phase), 32'd1);

    // freeze during EW green
    do_reset("frz");
    run_until(3, "frz");
    n = 0;
    for (int i = 0; i < 2; i++) begin step(1'b1, 1'b1, 1'b0, "frz"); n++; end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, "frz");
      check("frz_phase", 32'(phase), 32'd3);
    end
    for (int i = 0; i < 20 && phase == 3'd3; i++) begin
      step(1'b1, 1'b1, 1'b0, "frz");
      n++;
    end
    check("frz_ewg_len", 32'(n), 32'd8);
    check("frz_exit", 32'(phase), 32'd4);

    // reset in the middle of EW yellow, then restart cadence
    run_until(4, "mid");
    step(1'b1, 1'b1, 1'b0, "mid");
    do_reset("mid");
    step(1'b1, 1'b1, 1'b0, "mid");
    check("mid_first", 32'(phase), 32'd0);
    for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 1'b0, "mid");

    // pedestrian request during EW green cycle 2
    do_reset("ped");
    run_until(3, "ped");
    step(1'b1, 1'b1, 1'b1, "ped");
    saw_walk = 1'b0; walk_cnt = 0; ack_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b0, "ped");
      if (phase == 3'd6) saw_walk = 1'b1;
      if (walk) walk_cnt++;
      if (ped_ack) ack_cnt++;
    end
    check("ped_walk_seen", 32'(saw_walk), 32'(PED));
    check("ped_walk_len", 32'(walk_cnt), PED ? 32'd5 : 32'd0);
    check("ped_ack_cnt", 32'(ack_cnt), PED ? 32'd1 : 32'd0);

    // request on the clearing edge is kept for the following round
    do_reset("clr");
    for (int i = 0; i < 60 && !(phase == 3'd5); i++) step(1'b1, 1'b1, 1'b1, "clr");
    step(1'b1, 1'b1, 1'b1, "clr");
    check("clr_enter", 32'(phase), PED ? 32'd6 : 32'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b0, "clr");
      if (ped_ack) n++;
    end
    check("clr_second_walk", 32'(n), PED ? 32'd1 : 32'd0);

    // randomized traffic against the model
    do_reset("rnd");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset("rnd");
      else step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 7) == 0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intersection_controller.md
INTERSECTION_CONTROLLER -- requirements
Module: intersection_controller

Interface
REQ-001 Parameter GREEN_CYC, default 8, minimum green duration in clk cycles per direction.
REQ-002 Parameter YELLOW_CYC, default 3, yellow duration in cycles.
REQ-003 Parameter ALLRED_CYC, default 1, all-red clearance duration in cycles.
REQ-004 Parameter WALK_CYC, default 5, pedestrian walk duration in cycles.
REQ-005 Parameter TMR_W, default 8, phase timer width; every *_CYC value SHALL be in 1..2^TMR_W.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 enable  input  1  high = sequencing runs; low = state and timer frozen.
REQ-009 ew_sensor  input  1  high = vehicle waiting on east-west approach.
REQ-010 ped_req  input  1  pedestrian request; single-cycle or held pulse, level-sampled each edge.
REQ-011 ns_red, ns_yellow, ns_green  output  1 each  north-south lamps.
REQ-012 ew_red, ew_yellow, ew_green  output  1 each  east-west lamps.
REQ-013 walk  output  1  pedestrian walk lamp.
REQ-014 ped_ack  output  1  one-cycle pulse: pending request accepted.
REQ-015 phase  output  3  current state code.

Function
REQ-016 States and phase codes: NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5, WALK=6; codes 7 unused, recover to AR2.
REQ-017 Sequence: NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> (WALK if pedestrian pending, else NS_G); WALK -> NS_G.
REQ-018 Down-counting phase timer loads (duration-1) on state entry; state advances on edge where timer==0 and enable=1; each state lasts exactly its duration.
REQ-019 Durations: NS_G min GREEN_CYC; NS_Y, EW_Y YELLOW_CYC; AR1, AR2 ALLRED_CYC; EW_G exactly GREEN_CYC; WALK WALK_CYC.
REQ-020 NS_G with timer==0 holds (timer stays 0) while ew_sensor=0; exits to NS_Y on first edge with ew_sensor=1.
REQ-021 enable=0: state, timer, pending latch frozen; ped_req still latched; outputs unchanged.
REQ-022 Lamps are Moore decode of state: exactly one lamp per direction lit; red outside own G/Y states; all red in AR1, AR2, WALK.
REQ-023 walk=1 only in WALK; never while any green or yellow lit.
REQ-024 ped_req=1 sets pending latch on next edge; latch cleared on AR2->WALK transition; ped_ack=1 for exactly the first WALK cycle.
REQ-025 ped_req=1 on clearing edge: latch remains set; request served next cycle round.
REQ-026 Multiple requests before service coalesce into one WALK.
REQ-027 Illegal state code: next edge -> AR2, timer loaded ALLRED_CYC-1.

Reset
REQ-028 reset=1 forces immediately: state AR2, timer ALLRED_CYC-1, pending latch 0.
REQ-029 During/after reset: ns_red=1, ew_red=1, other lamps 0, walk=0, ped_ack=0, phase=5.
REQ-030 Reset mid-phase aborts the phase; first edge after release counts AR2 normally.

Configuration
REQ-031 Macro INTERSECTION_PED_EN defined: pending latch, WALK state, walk and ped_ack behave per REQ-023..026.
REQ-032 Macro undefined: ped_req ignored, no latch, AR2 -> NS_G always, walk and ped_ack tied 0, phase never 6.

Verification
REQ-033 Defaults, ew_sensor=1, enable=1, reset released -> AR2 1 cycle then repeating NS_G 8, NS_Y 3, AR1 1, EW_G 8, EW_Y 3, AR2 1 (24-cycle period).
REQ-034 ew_sensor=0 throughout NS_G, raised at NS_G cycle 20 -> NS_Y from next edge, NS_G lasted 21 cycles.
REQ-035 ped_req pulse in EW_G cycle 2 (macro defined) -> after AR2, WALK 5 cycles, walk=1, all red, ped_ack=1 only in first WALK cycle; next round no WALK.
REQ-036 enable=0 for 10 cycles at EW_G cycle 3 -> phase stays 3, EW_G totals 8 enabled cycles after enable returns high.
REQ-037 reset asserted mid-EW_Y -> same cycle all red, phase=5; sequence restarts per REQ-033.
REQ-038 Macro undefined, ped_req held high -> walk=0, ped_ack=0, phase never 6, timing identical to REQ-033.
